// File: rtl/rom_add_seq.sv
// rom_add_seq
// Sequencer for the dual-ROM adder datapath. When start is seen in IDLE it
// latches two base addresses and a pair count. It then walks both ROMs in
// lockstep and registers each byte sum with a one-cycle valid strobe. It also
// keeps a running total of every pair in the current run. The two 16x8
// async-read ROMs sit outside this block.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 run request, only honoured in IDLE
//   hold                  stalls the walk while in RUN
//   base1, base2          first address for each ROM, latched at start
//   count                 number of pairs, latched at start (0 means 2**AW)
//   rom1_addr, rom2_addr  registered ROM addresses
//   rom1_data, rom2_data  combinational ROM read data
//   sum_out, sum_carry    registered byte sum and its carry-out
//   sum_valid             one-cycle strobe per registered sum
//   total                 accumulated sum of all pairs in the current run
//   busy                  high in RUN and DONE
//   done                  one-cycle pulse when a run completes
module rom_add_seq #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int TW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  input  logic [AW-1:0] base1,
  input  logic [AW-1:0] base2,
  input  logic [AW:0]   count,
  output logic [AW-1:0] rom1_addr,
  output logic [AW-1:0] rom2_addr,
  input  logic [DW-1:0] rom1_data,
  input  logic [DW-1:0] rom2_data,
  output logic [DW-1:0] sum_out,
  output logic          sum_carry,
  output logic          sum_valid,
  output logic [TW-1:0] total,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full-width add, so the carry lands in the top bit.
  function automatic logic [DW:0] pair_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  state_t        state_r, state_s;
  logic [AW:0]   rem_r, rem_s;
  logic [AW-1:0] addr1_r, addr1_s;
  logic [AW-1:0] addr2_r, addr2_s;
  logic [DW-1:0] sum_r, sum_s;
  logic          carry_r, carry_s;
  logic          valid_r, valid_s;
  logic [TW-1:0] total_r, total_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [DW:0]   pair_sum_s;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_s    = state_r;
    rem_s      = rem_r;
    addr1_s    = addr1_r;
    addr2_s    = addr2_r;
    sum_s      = sum_r;
    carry_s    = carry_r;
    valid_s    = 1'b0;
    total_s    = total_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    pair_sum_s = pair_add(rom1_data, rom2_data);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          addr1_s = base1;
          addr2_s = base2;
          // A zero count stands for a full sweep of the ROM.
          rem_s   = (count == {(AW+1){1'b0}}) ? {1'b1, {AW{1'b0}}} : count;
          total_s = {TW{1'b0}};
          carry_s = 1'b0;
          busy_s  = 1'b1;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          sum_s   = pair_sum_s[DW-1:0];
          carry_s = pair_sum_s[DW];
          total_s = total_r + {{(TW-DW-1){1'b0}}, pair_sum_s};
          valid_s = 1'b1;
          // The two addresses wrap independently at the ROM depth.
          addr1_s = addr1_r + {{(AW-1){1'b0}}, 1'b1};
          addr2_s = addr2_r + {{(AW-1){1'b0}}, 1'b1};
          rem_s   = rem_r - {{AW{1'b0}}, 1'b1};
          if (rem_r == {{AW{1'b0}}, 1'b1}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        // busy drops on the same edge that raises done, so they never overlap.
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      rem_r   <= {(AW+1){1'b0}};
      addr1_r <= {AW{1'b0}};
      addr2_r <= {AW{1'b0}};
      sum_r   <= {DW{1'b0}};
      carry_r <= 1'b0;
      valid_r <= 1'b0;
      total_r <= {TW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      addr1_r <= addr1_s;
      addr2_r <= addr2_s;
      sum_r   <= sum_s;
      carry_r <= carry_s;
      valid_r <= valid_s;
      total_r <= total_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign rom1_addr = addr1_r;
  assign rom2_addr = addr2_r;
  assign sum_out   = sum_r;
  assign sum_carry = carry_r;
  assign sum_valid = valid_r;
  assign total     = total_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_rom_add_seq.sv
// tb_rom_add_seq
// Self-checking bench for rom_add_seq. It models both ROMs as mem[i] = {i,i}
// and predicts every sum from the ROM formula 0x11*addr. Each cycle it checks
// strobes, totals, addresses and the busy/done handshake.
module tb_rom_add_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       hold;
  logic [3:0] base1;
  logic [3:0] base2;
  logic [4:0] count;
  logic [3:0] rom1_addr;
  logic [3:0] rom2_addr;
  logic [7:0] rom1_data;
  logic [7:0] rom2_data;
  logic [7:0] sum_out;
  logic       sum_carry;
  logic       sum_valid;
  logic [12:0] total;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  rom_add_seq #(.AW(4), .DW(8), .TW(13)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .base1(base1), .base2(base2), .count(count),
    .rom1_addr(rom1_addr), .rom2_addr(rom2_addr),
    .rom1_data(rom1_data), .rom2_data(rom2_data),
    .sum_out(sum_out), .sum_carry(sum_carry), .sum_valid(sum_valid),
    .total(total), .busy(busy), .done(done)
  );

  function automatic logic [7:0] rom_word(input logic [3:0] a);
    return {a, a};
  endfunction

  assign rom1_data = rom_word(rom1_addr);
  assign rom2_data = rom_word(rom2_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One run. hold_kind: 0 none, 1 three holds after first sum, 2 random.
  // start_kind: 0 none, 1 stray start on a RUN edge, 2 random stray starts
  // including the DONE->IDLE edge. abort_at>0 resets after that many sums.
  task automatic run_case(input string tag, input int b1, input int b2, input int cnt,
                          input int hold_kind, input int start_kind, input int abort_at);
    int n;
    int k;
    int held;
    int s;
    int exp_total;
    int done_seen;
    int last_sum;
    int last_carry;
    bit h;
    bit finished;
    bit aborted;
    n = (cnt == 0) ? 16 : cnt;
    k = 0; held = 0; exp_total = 0; done_seen = 0;
    last_sum = 0; last_carry = 0;
    finished = 1'b0; aborted = 1'b0;

    @(negedge clk);
    base1 = 4'(b1); base2 = 4'(b2); count = 5'(cnt);
    start = 1'b1; hold = 1'b0; rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "/start_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "/start_total"}, 32'(total), 32'd0);
    check_eq({tag, "/start_addr1"}, 32'(rom1_addr), 32'(b1 % 16));
    check_eq({tag, "/start_addr2"}, 32'(rom2_addr), 32'(b2 % 16));
    // Inputs changing after the start edge must not disturb the run.
    base1 = 4'($urandom); base2 = 4'($urandom); count = 5'($urandom);

    for (int cyc = 0; cyc < 120 && !finished; cyc++) begin
      case (hold_kind)
        0:       h = 1'b0;
        1:       h = (k == 1 && held < 3);
        default: h = ($urandom_range(0, 3) == 0);
      endcase
      if (hold_kind == 1 && h) held++;
      hold  = h;
      start = (start_kind == 1 && cyc == 1) ||
              (start_kind == 2 && ($urandom_range(0, 3) == 0 || k == n));
      rst   = (abort_at > 0 && k == abort_at);
      @(negedge clk);
      if (rst) begin
        aborted  = 1'b1;
        finished = 1'b1;
        check_eq({tag, "/abort_sum"}, 32'(sum_out), 32'd0);
        check_eq({tag, "/abort_carry"}, 32'(sum_carry), 32'd0);
        check_eq({tag, "/abort_valid"}, 32'(sum_valid), 32'd0);
        check_eq({tag, "/abort_total"}, 32'(total), 32'd0);
        check_eq({tag, "/abort_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "/abort_done"}, 32'(done), 32'd0);
        check_eq({tag, "/abort_addr"}, 32'({rom1_addr, rom2_addr}), 32'd0);
      end else if (k < n) begin
        if (!h) begin
          s = 17 * ((b1 + k) % 16) + 17 * ((b2 + k) % 16);
          k++;
          exp_total += s;
          last_sum = s % 256;
          last_carry = s / 256;
          check_eq({tag, "/valid"}, 32'(sum_valid), 32'd1);
          check_eq({tag, "/sum"}, 32'(sum_out), 32'(last_sum));
          check_eq({tag, "/carry"}, 32'(sum_carry), 32'(last_carry));
        end else begin
          check_eq({tag, "/hold_valid"}, 32'(sum_valid), 32'd0);
          if (k > 0) check_eq({tag, "/hold_sum"}, 32'(sum_out), 32'(last_sum));
        end
        check_eq({tag, "/total"}, 32'(total), 32'(exp_total));
        check_eq({tag, "/run_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "/run_done"}, 32'(done), 32'd0);
        check_eq({tag, "/addr1"}, 32'(rom1_addr), 32'((b1 + k) % 16));
        check_eq({tag, "/addr2"}, 32'(rom2_addr), 32'((b2 + k) % 16));
      end else begin
        finished = 1'b1;
        check_eq({tag, "/done"}, 32'(done), 32'd1);
        check_eq({tag, "/done_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "/done_valid"}, 32'(sum_valid), 32'd0);
        check_eq({tag, "/done_total"}, 32'(total), 32'(exp_total));
      end
    end
    start = 1'b0; hold = 1'b0; rst = 1'b0;
    if (!finished) check_eq({tag, "/timeout"}, 32'd0, 32'd1);

    if (aborted) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done || busy) done_seen++;
      end
      check_eq({tag, "/no_done_after_abort"}, 32'(done_seen), 32'd0);
    end else begin
      @(negedge clk);
      check_eq({tag, "/idle_done"}, 32'(done), 32'd0);
      check_eq({tag, "/idle_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "/idle_sum"}, 32'(sum_out), 32'(last_sum));
      check_eq({tag, "/idle_total"}, 32'(total), 32'(exp_total));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    base1 = 4'd0; base2 = 4'd0; count = 5'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_sum", 32'(sum_out), 32'd0);
    check_eq("reset_flags", 32'({sum_carry, sum_valid, busy, done}), 32'd0);
    check_eq("reset_total", 32'(total), 32'd0);
    check_eq("reset_addr", 32'({rom1_addr, rom2_addr}), 32'd0);
    rst = 1'b0;

    run_case("T1", 2, 3, 2, 0, 0, 0);
    run_case("T2", 15, 15, 2, 0, 0, 0);
    run_case("T3", 0, 0, 0, 0, 0, 0);
    run_case("T4", 2, 3, 2, 1, 0, 0);
    run_case("T5", 2, 3, 2, 0, 1, 0);
    run_case("T6", 0, 0, 0, 0, 0, 1);
    run_case("T6b", 2, 3, 2, 0, 0, 0);
    for (int r = 0; r < 20; r++) begin
      run_case("RND", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 16)), 2, 2, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
